// File: rtl/csr_file_if.sv
// Write-back/trap channel into the CSR file: one request per cycle, qualified by valid.
interface csr_wif #(
  parameter int unsigned XLEN = 32
);
  logic [11:0]     addr;
  logic [XLEN-1:0] data;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] cause;
  logic            trap;
  logic            valid;

  modport req (output addr, data, pc, cause, trap, valid);
  modport rsp (input  addr, data, pc, cause, trap, valid);
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational read port, single write/trap channel, MRET handling.
// Define CSR_COUNTERS_EN to add the 64-bit mcycle/minstret counters and their user shadows.
module csr_file #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned HART_ID = 0
) (
  input  logic            clk,
  input  logic            rst,
  csr_wif.rsp             wbcsr_wif,
  input  logic [11:0]     raddr,
  output logic [XLEN-1:0] rdata,
  output logic            rillegal,
  input  logic            mret,
  input  logic            instret_inc,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o
);

  typedef enum logic [11:0] {
    CSR_MSTATUS   = 12'h300,
    CSR_MISA      = 12'h301,
    CSR_MIE       = 12'h304,
    CSR_MTVEC     = 12'h305,
    CSR_MSCRATCH  = 12'h340,
    CSR_MEPC      = 12'h341,
    CSR_MCAUSE    = 12'h342,
    CSR_MTVAL     = 12'h343,
    CSR_MIP       = 12'h344,
    CSR_MCYCLE    = 12'hB00,
    CSR_MINSTRET  = 12'hB02,
    CSR_MCYCLEH   = 12'hB80,
    CSR_MINSTRETH = 12'hB82,
    CSR_CYCLE     = 12'hC00,
    CSR_INSTRET   = 12'hC02,
    CSR_CYCLEH    = 12'hC80,
    CSR_INSTRETH  = 12'hC82,
    CSR_MHARTID   = 12'hF14
  } csr_addr_e;

  logic            st_mie, st_mpie;
  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [XLEN-1:0] mstatus_rd;
  logic            trap_fire, we;

  assign trap_fire = wbcsr_wif.valid && wbcsr_wif.trap;
  // addr[11:10]==2'b11 is the read-only CSR space; writes there are dropped.
  assign we        = wbcsr_wif.valid && !wbcsr_wif.trap && (wbcsr_wif.addr[11:10] != 2'b11);

  assign mstatus_rd = XLEN'({19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0});
  assign mtvec_o    = mtvec_q;
  assign mepc_o     = mepc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else if (trap_fire) begin
      mepc_q   <= wbcsr_wif.pc & ~XLEN'(3);
      mcause_q <= wbcsr_wif.cause;
      mtval_q  <= '0;
      st_mpie  <= st_mie;
      st_mie   <= 1'b0;
    end else begin
      if (mret) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end
      if (we) begin
        case (wbcsr_wif.addr)
          CSR_MSTATUS: begin
            // MRET owns mstatus this cycle; a concurrent write is lost.
            if (!mret) begin
              st_mie  <= wbcsr_wif.data[3];
              st_mpie <= wbcsr_wif.data[7];
            end
          end
          CSR_MIE:      mie_q      <= wbcsr_wif.data;
          CSR_MTVEC:    mtvec_q    <= wbcsr_wif.data & ~XLEN'(3);
          CSR_MSCRATCH: mscratch_q <= wbcsr_wif.data;
          CSR_MEPC:     mepc_q     <= wbcsr_wif.data & ~XLEN'(3);
          CSR_MCAUSE:   mcause_q   <= wbcsr_wif.data;
          CSR_MTVAL:    mtval_q    <= wbcsr_wif.data;
          default:      ;
        endcase
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, minstret_q;

  // A write to one half replaces that half only; the increment is skipped that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (we && wbcsr_wif.addr == CSR_MCYCLE)
        mcycle_q[31:0] <= wbcsr_wif.data[31:0];
      else if (we && wbcsr_wif.addr == CSR_MCYCLEH)
        mcycle_q[63:32] <= wbcsr_wif.data[31:0];
      else
        mcycle_q <= mcycle_q + 64'd1;

      if (we && wbcsr_wif.addr == CSR_MINSTRET)
        minstret_q[31:0] <= wbcsr_wif.data[31:0];
      else if (we && wbcsr_wif.addr == CSR_MINSTRETH)
        minstret_q[63:32] <= wbcsr_wif.data[31:0];
      else if (instret_inc)
        minstret_q <= minstret_q + 64'd1;
    end
  end
`else
  logic unused_instret;
  assign unused_instret = instret_inc;
`endif

  always_comb begin
    rdata    = '0;
    rillegal = 1'b0;
    case (raddr)
      CSR_MSTATUS:  rdata = mstatus_rd;
      CSR_MISA:     rdata = XLEN'(32'h4000_0100);
      CSR_MIE:      rdata = mie_q;
      CSR_MTVEC:    rdata = mtvec_q;
      CSR_MSCRATCH: rdata = mscratch_q;
      CSR_MEPC:     rdata = mepc_q;
      CSR_MCAUSE:   rdata = mcause_q;
      CSR_MTVAL:    rdata = mtval_q;
      CSR_MIP:      rdata = '0;
      CSR_MHARTID:  rdata = XLEN'(HART_ID);
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE,    CSR_CYCLE:    rdata = XLEN'(mcycle_q[31:0]);
      CSR_MCYCLEH,   CSR_CYCLEH:   rdata = XLEN'(mcycle_q[63:32]);
      CSR_MINSTRET,  CSR_INSTRET:  rdata = XLEN'(minstret_q[31:0]);
      CSR_MINSTRETH, CSR_INSTRETH: rdata = XLEN'(minstret_q[63:32]);
`endif
      default:      rillegal = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_csr_file.sv
// Randomized bench for csr_file against a table-driven CSR model (value + write mask per address).
module tb_csr_file;
  localparam int unsigned HART = 7;

  logic        clk;
  logic        rst;
  logic [11:0] raddr;
  logic [31:0] rdata;
  logic        rillegal;
  logic        mret;
  logic        instret_inc;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;

  int tests = 0;
  int fails = 0;

  csr_wif #(.XLEN(32)) wif ();

  csr_file #(.XLEN(32), .HART_ID(HART)) dut (
    .clk         (clk),
    .rst         (rst),
    .wbcsr_wif   (wif),
    .raddr       (raddr),
    .rdata       (rdata),
    .rillegal    (rillegal),
    .mret        (mret),
    .instret_inc (instret_inc),
    .mtvec_o     (mtvec_o),
    .mepc_o      (mepc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: implemented CSRs as value/write-mask tables, counters as 64-bit numbers.
  logic [31:0] mcsr [int];
  logic [31:0] mwm  [int];
  logic [63:0] m_cyc, m_ins;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mcsr.delete();
    mwm.delete();
    mcsr['h300] = 32'h0000_1800; mwm['h300] = 32'h0000_0088;
    mcsr['h301] = 32'h4000_0100; mwm['h301] = 32'h0;
    mcsr['h304] = 32'h0;         mwm['h304] = 32'hFFFF_FFFF;
    mcsr['h305] = 32'h0;         mwm['h305] = 32'hFFFF_FFFC;
    mcsr['h340] = 32'h0;         mwm['h340] = 32'hFFFF_FFFF;
    mcsr['h341] = 32'h0;         mwm['h341] = 32'hFFFF_FFFC;
    mcsr['h342] = 32'h0;         mwm['h342] = 32'hFFFF_FFFF;
    mcsr['h343] = 32'h0;         mwm['h343] = 32'hFFFF_FFFF;
    mcsr['h344] = 32'h0;         mwm['h344] = 32'h0;
    mcsr['hF14] = HART;          mwm['hF14] = 32'h0;
    m_cyc = '0;
    m_ins = '0;
  endtask

  task automatic model_edge(input logic v, input logic t, input logic [11:0] a, input logic [31:0] d,
                            input logic [31:0] p, input logic [31:0] c, input logic mr, input logic inc);
    logic [31:0] st;
    bit cw, iw;
    cw = 0;
    iw = 0;
    st = mcsr['h300];
    if (v && t) begin
      mcsr['h341] = p & 32'hFFFF_FFFC;
      mcsr['h342] = c;
      mcsr['h343] = 32'h0;
      mcsr['h300] = (st & ~32'h88) | (st[3] ? 32'h80 : 32'h0);
    end else begin
      if (mr)
        mcsr['h300] = (st & ~32'h88) | 32'h80 | (st[7] ? 32'h8 : 32'h0);
      if (v && !(mr && a == 12'h300) && mwm.exists(int'(a)))
        mcsr[int'(a)] = (mcsr[int'(a)] & ~mwm[int'(a)]) | (d & mwm[int'(a)]);
`ifdef CSR_COUNTERS_EN
      if (v) begin
        case (a)
          12'hB00: begin m_cyc[31:0]  = d; cw = 1; end
          12'hB80: begin m_cyc[63:32] = d; cw = 1; end
          12'hB02: begin m_ins[31:0]  = d; iw = 1; end
          12'hB82: begin m_ins[63:32] = d; iw = 1; end
          default: ;
        endcase
      end
`endif
    end
    if (!cw) m_cyc = m_cyc + 64'd1;
    if (!iw && inc) m_ins = m_ins + 64'd1;
  endtask

  function automatic logic [32:0] mread(input logic [11:0] a);
    if (mcsr.exists(int'(a))) return {1'b0, mcsr[int'(a)]};
`ifdef CSR_COUNTERS_EN
    case (a)
      12'hB00, 12'hC00: return {1'b0, m_cyc[31:0]};
      12'hB80, 12'hC80: return {1'b0, m_cyc[63:32]};
      12'hB02, 12'hC02: return {1'b0, m_ins[31:0]};
      12'hB82, 12'hC82: return {1'b0, m_ins[63:32]};
      default: ;
    endcase
`endif
    return {1'b1, 32'h0};
  endfunction

  task automatic clear_inputs();
    wif.valid = 1'b0; wif.trap = 1'b0; wif.addr = '0; wif.data = '0;
    wif.pc = '0; wif.cause = '0; mret = 1'b0; instret_inc = 1'b0;
  endtask

  task automatic step(input logic v, input logic t, input logic [11:0] a, input logic [31:0] d,
                      input logic [31:0] p, input logic [31:0] c, input logic mr, input logic inc);
    wif.valid = v; wif.trap = t; wif.addr = a; wif.data = d;
    wif.pc = p; wif.cause = c; mret = mr; instret_inc = inc;
    @(posedge clk);
    model_edge(v, t, a, d, p, c, mr, inc);
    #1;
    clear_inputs();
    check("mtvec_o", mtvec_o, mcsr['h305]);
    check("mepc_o", mepc_o, mcsr['h341]);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, a, d, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 12'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic rd_check(input string tag, input logic [11:0] a);
    logic [32:0] r;
    raddr = a;
    #1;
    r = mread(a);
    check(tag, rdata, r[31:0]);
    check({tag, "_ill"}, rillegal, r[32]);
  endtask

  logic [11:0] alist [18] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                              12'h342, 12'h343, 12'h344, 12'hF14, 12'h7C0, 12'h000,
                              12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC02};

  task automatic rand_steps(input int n);
    for (int i = 0; i < n; i++) begin
      logic [11:0] a;
      a = alist[$urandom_range(0, 17)];
      step($urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, a, $urandom(), $urandom(),
           $urandom(), $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
      rd_check("rand_rd", alist[$urandom_range(0, 17)]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    raddr = '0;
    clear_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mtvec", mtvec_o, 32'h0);
    check("rst_mepc", mepc_o, 32'h0);
    raddr = 12'h300;
    #1;
    check("rst_mstatus", rdata, 32'h0000_1800);
    rd_check("rst_misa", 12'h301);

    // mtvec low bits forced to zero
    wr(12'h305, 32'h8000_0103);
    check("mtvec_dir", mtvec_o, 32'h8000_0100);
    raddr = 12'h305;
    #1;
    check("mtvec_rd", rdata, 32'h8000_0100);

    // trap then mret
    wr(12'h300, 32'h0000_0008);
    step(1'b1, 1'b1, 12'h0, 32'h0, 32'h0000_1006, 32'h2, 1'b0, 1'b0);
    check("trap_mepc", mepc_o, 32'h0000_1004);
    raddr = 12'h342;
    #1;
    check("trap_mcause", rdata, 32'h2);
    raddr = 12'h300;
    #1;
    check("trap_mstatus", rdata, 32'h0000_1880);
    step(1'b0, 1'b0, 12'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    raddr = 12'h300;
    #1;
    check("mret_mstatus", rdata, 32'h0000_1888);

    // trap + mret + mstatus write together: trap alone wins
    step(1'b1, 1'b1, 12'h300, 32'h0, 32'h0000_2002, 32'h8000_000B, 1'b1, 1'b0);
    check("prio_mepc", mepc_o, 32'h0000_2000);
    raddr = 12'h300;
    #1;
    check("prio_mstatus", rdata, 32'h0000_1880);
    rd_check("prio_mtval", 12'h343);

    // mret + mstatus write: write dropped
    step(1'b1, 1'b0, 12'h300, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    raddr = 12'h300;
    #1;
    check("mret_wr_mstatus", rdata, 32'h0000_1888);

    // read-only and unimplemented
    wr(12'hF14, 32'hFFFF_FFFF);
    raddr = 12'hF14;
    #1;
    check("mhartid", rdata, HART);
    raddr = 12'h7C0;
    #1;
    check("unimpl_data", rdata, 32'h0);
    check("unimpl_ill", rillegal, 1'b1);

`ifdef CSR_COUNTERS_EN
    wr(12'hB80, 32'h0);
    wr(12'hB00, 32'hFFFF_FFFF);
    idle();
    idle();
    raddr = 12'hB00;
    #1;
    check("mcycle_lo", rdata, 32'h1);
    raddr = 12'hB80;
    #1;
    check("mcycle_hi", rdata, 32'h1);
    wr(12'hB82, 32'h0);
    wr(12'hB02, 32'h0);
    repeat (5) step(1'b0, 1'b0, 12'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    raddr = 12'hB02;
    #1;
    check("minstret5", rdata, 32'h5);
`else
    raddr = 12'hB00;
    #1;
    check("nocnt_ill", rillegal, 1'b1);
    check("nocnt_data", rdata, 32'h0);
`endif

    // asynchronous reset mid-cycle with a trap pending
    wif.valid = 1'b1; wif.trap = 1'b1; wif.pc = 32'h0000_3000; wif.cause = 32'h7;
    mret = 1'b1; instret_inc = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("arst_mtvec", mtvec_o, 32'h0);
    check("arst_mepc", mepc_o, 32'h0);
    raddr = 12'h300;
    #1;
    check("arst_mstatus", rdata, 32'h0000_1800);
    rd_check("arst_minstret", 12'hB02);
    repeat (2) @(posedge clk);
    #1;
    check("arst_hold_mepc", mepc_o, 32'h0);
    rd_check("arst_hold_mstatus", 12'h300);
    rd_check("arst_hold_mcycle", 12'hB00);
    clear_inputs();
    rst = 1'b0;

    rand_steps(400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
